arbitro_somador_subtrator: RTL

Shares the coprocessor's single 8-bit adder/subtractor between two requesters, each using a valid/ready handshake. Arbitration is round-robin. The block registers the operands, runs one operation through the datapath, and holds the 9-bit result on a response channel until the consumer accepts it. It sits between the command decoders and the arithmetic datapath, and keeps a count of completed operations.

---
 rtl/arbitro_somador_subtrator_pkg.sv | 20 ++
 rtl/modulo_somador_subtrator.sv | 31 +++
 rtl/arbitro_somador_subtrator.sv | 127 ++++++++++++
 3 files changed

// File: rtl/arbitro_somador_subtrator_pkg.sv
// Shared definitions for the adder/subtractor arbiter and its datapath.
//   DATA_W  : operand width of the shared datapath
//   RES_W   : datapath result width (operand width plus status bit)
//   estado_t: controller states IDLE / EXEC / RESP (2-bit encoding)
//   OP_SOMA / OP_SUB: op select values (add / subtract)
package arbitro_somador_subtrator_pkg;

    localparam int DATA_W = 8;
    localparam int RES_W  = DATA_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } estado_t;

    localparam logic OP_SOMA = 1'b0;
    localparam logic OP_SUB  = 1'b1;

endpackage

// File: rtl/modulo_somador_subtrator.sv
// Shared 8-bit adder/subtractor datapath (purely combinational).
// Ports:
//   a, b      : operands
//   op        : 0 = add, 1 = subtract
//   resultado : low DATA_W bits = result mod 2^DATA_W; top bit = status
//               add: carry XOR sum MSB; subtract: 1 iff a >= b (unsigned)
module modulo_somador_subtrator
    import arbitro_somador_subtrator_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              op,
    output logic [RES_W-1:0]  resultado
);

    logic [DATA_W:0] soma;
    logic [DATA_W:0] dif;

    always_comb begin
        soma      = {1'b0, a} + {1'b0, b};
        dif       = {1'b0, a} - {1'b0, b};
        resultado = '0;
        case (op)
            OP_SOMA: resultado = {soma[DATA_W] ^ soma[DATA_W-1], soma[DATA_W-1:0]};
            // The extended difference borrows into its top bit when a < b.
            OP_SUB:  resultado = {~dif[DATA_W], dif[DATA_W-1:0]};
            default: resultado = '0;
        endcase
    end

endmodule

// File: rtl/arbitro_somador_subtrator.sv
// Round-robin arbiter sharing one adder/subtractor between two requesters.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   reqN_valid/ready/a/b/op (N=0,1): request channels (valid/ready)
//   resp_valid/ready/id/resultado  : response channel, held until accepted
//   busy                           : controller not in IDLE
//   cont_ops                       : completed responses, wraps at 2^CNT_W
module arbitro_somador_subtrator
    import arbitro_somador_subtrator_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic              req1_op,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [DATA_W:0]   resp_resultado,
    output logic              busy,
    output logic [CNT_W-1:0]  cont_ops
);

    estado_t           estado;
    estado_t           prox_estado;
    logic              ptr;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic              op_reg;
    logic              id_reg;
    logic              tem_pedido;
    logic              id_conc;
    logic              aceita;
    logic [DATA_W:0]   resultado_dp;

    // Grant selection: a lone requester wins outright, the pointer breaks ties.
    always_comb begin
        tem_pedido = req0_valid | req1_valid;
        id_conc    = (req0_valid && req1_valid) ? ptr : req1_valid;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            estado <= ST_IDLE;
        end else begin
            estado <= prox_estado;
        end
    end

    // Next-state logic
    always_comb begin
        prox_estado = estado;
        case (estado)
            ST_IDLE: if (tem_pedido) prox_estado = ST_EXEC;
            ST_EXEC: prox_estado = ST_RESP;
            ST_RESP: if (resp_ready) prox_estado = ST_IDLE;
            default: prox_estado = ST_IDLE;
        endcase
    end

    // Output logic. Ready is withheld while rst is high so a requester never
    // sees an acceptance that the reset edge is about to discard.
    always_comb begin
        aceita     = (estado == ST_IDLE) && tem_pedido && !rst;
        req0_ready = aceita && !id_conc;
        req1_ready = aceita && id_conc;
        busy       = (estado != ST_IDLE);
    end

    // Operand capture, response registers, pointer and completion counter
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr            <= 1'b0;
            a_reg          <= '0;
            b_reg          <= '0;
            op_reg         <= 1'b0;
            id_reg         <= 1'b0;
            resp_valid     <= 1'b0;
            resp_id        <= 1'b0;
            resp_resultado <= '0;
            cont_ops       <= '0;
        end else begin
            case (estado)
                ST_IDLE: begin
                    if (tem_pedido) begin
                        a_reg  <= id_conc ? req1_a  : req0_a;
                        b_reg  <= id_conc ? req1_b  : req0_b;
                        op_reg <= id_conc ? req1_op : req0_op;
                        id_reg <= id_conc;
                        ptr    <= ~id_conc;
                    end
                end
                ST_EXEC: begin
                    resp_resultado <= resultado_dp;
                    resp_id        <= id_reg;
                    resp_valid     <= 1'b1;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        cont_ops   <= cont_ops + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    modulo_somador_subtrator u_datapath (
        .a         (a_reg),
        .b         (b_reg),
        .op        (op_reg),
        .resultado (resultado_dp)
    );

endmodule
